// File: rtl/vedic_pkg.sv
// Shared types and constants for the digit-serial Vedic multiplier.
package vedic_pkg;

  localparam int VEDIC_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int vedic_digits(input int width);
    return width / VEDIC_DIGIT_W;
  endfunction

endpackage

// File: rtl/simple_vedic_4bit.sv
// Combinational 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier built from
// four 2x2 Vedic blocks.
module simple_vedic_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  assign q0  = vm2(a_i[1:0], b_i[1:0]);
  assign q1  = vm2(a_i[3:2], b_i[1:0]);
  assign q2  = vm2(a_i[1:0], b_i[3:2]);
  assign q3  = vm2(a_i[3:2], b_i[3:2]);
  // Cross terms share weight 2^2 and are summed before the final add.
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p_o = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};

endmodule

// File: rtl/vedic_serial_mult.sv
// Digit-serial WIDTH x WIDTH multiplier sharing one 4x4 Vedic core.
// Optional VEDIC_SERIAL_SKIP_ZERO_EN: zero operand bypasses MUL straight to DONE.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | one digit-pair partial product accumulated per cycle
// DONE  | product presented, waiting for out_ready
module vedic_serial_mult
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int D  = vedic_digits(WIDTH);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  if ((WIDTH % VEDIC_DIGIT_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("vedic_serial_mult: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d;
  logic [3:0]         dig_a, dig_b;
  logic [7:0]         prod;
  logic [CW+2:0]      sh;
  logic [2*WIDTH-1:0] pp;
  logic               start_zero;

  assign dig_a = a_q[{i_q, 2'b00} +: VEDIC_DIGIT_W];
  assign dig_b = b_q[{j_q, 2'b00} +: VEDIC_DIGIT_W];

  simple_vedic_4bit u_mul (
    .a_i (dig_a),
    .b_i (dig_b),
    .p_o (prod)
  );

  assign sh = {1'b0, i_q, 2'b00} + {1'b0, j_q, 2'b00};
  assign pp = {{(2*WIDTH-8){1'b0}}, prod} << sh;

`ifdef VEDIC_SERIAL_SKIP_ZERO_EN
  assign start_zero = (a == '0) || (b == '0);
`else
  assign start_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = start_zero ? DONE : MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + pp;
        if (i_q == LAST) begin
          i_d = '0;
          if (j_q == LAST) state_d = DONE;
          else             j_d     = j_q + CW'(1);
        end else begin
          i_d = i_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = acc_q;

endmodule

// File: tb/tb_vedic_serial_mult.sv
// Self-checking bench for vedic_serial_mult: latency/handshake model plus
// literal products, with a second WIDTH=8 instance.
module tb_vedic_serial_mult;

  localparam int W = 16;
  localparam int D = W / 4;
`ifdef VEDIC_SERIAL_SKIP_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = D * D + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  a_s, b_s;
  logic [2*W-1:0] p_s;

  logic          in_valid8, in_ready8, out_valid8, busy8;
  logic [7:0]    a8, b8;
  logic [15:0]   p8;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  always #5 clk = ~clk;

  vedic_serial_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_s), .b(b_s), .out_valid(out_valid), .out_ready(out_ready),
    .p(p_s), .busy(busy)
  );

  vedic_serial_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
    .p(p8), .busy(busy8)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_asserts++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: an accepted pair yields a*b after a fixed latency, held until out_ready.
  bit             chk_en = 0;
  bit             m_active, m_valid;
  int             m_wait;
  logic [2*W-1:0] m_exp;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0;
      m_valid  <= 0;
      m_wait   <= 0;
      m_exp    <= '0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid  <= 0;
        m_active <= 0;
      end
    end else if (m_active) begin
      if (m_wait == 1) m_valid <= 1;
      m_wait <= m_wait - 1;
    end else if (in_valid) begin
      m_active <= 1;
      m_exp    <= {{W{1'b0}}, a_s} * {{W{1'b0}}, b_s};
      if (ZERO_LAT == 1 && (a_s == 0 || b_s == 0)) m_valid <= 1;
      else m_wait <= D * D;
    end
  end

  bit ov_prev = 0;
  int rise_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_active);
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_active);
      if (m_valid) check("p", p_s, m_exp);
    end
    if (out_valid && !ov_prev) rise_q.push_back(cyc);
    ov_prev = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns tacc = cycle count in the cycle after the accept edge (T+1).
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit keep,
                      output int tacc);
    in_valid = 1;
    a_s = xa;
    b_s = xb;
    tacc = -1;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        tick();
        tacc = cyc;
        if (!keep) in_valid = 0;
        return;
      end
      tick();
    end
    timeout("send");
  endtask

  // lat counts cycles from accept (T) to the first cycle with out_valid.
  task automatic get(input int tacc, output int lat, output logic [2*W-1:0] pv);
    lat = -1;
    pv  = '0;
    for (int k = 0; k < 200; k++) begin
      if (out_valid) begin
        lat = cyc - tacc + 1;
        pv  = p_s;
        return;
      end
      tick();
    end
    timeout("get");
  endtask

  initial begin
    int t, lat, ov, t0;
    int acc_t[$];
    logic [2*W-1:0] pv;

    rst = 1; in_valid = 0; out_ready = 0; a_s = '0; b_s = '0;
    in_valid8 = 0; a8 = '0; b8 = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p_s, 0);
    rst = 0;
    chk_en = 1;

    out_ready = 1;
    send(16'h1234, 16'h5678, 0, t);
    get(t, lat, pv);
    check("basic_lat", lat, 17);
    check("basic_p", pv, 32'h06260060);
    tick();

    send(16'hFFFF, 16'hFFFF, 0, t);
    get(t, lat, pv);
    check("max_p", pv, 32'hFFFE0001);
    tick();

    out_ready = 0;
    send(16'h0F0F, 16'h3C3C, 0, t);
    get(t, lat, pv);
    check("bp_p_value", pv, 32'h0F0F * 32'h3C3C);
    in_valid = 1; a_s = 16'h1111; b_s = 16'h2222;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_p_hold", p_s, pv);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    send(16'h0000, 16'h1234, 0, t);
    get(t, lat, pv);
    check("zero_lat", lat, ZERO_LAT);
    check("zero_p", pv, 0);
    tick();

    send(16'hABCD, 16'h1111, 0, t);
    repeat (7) tick();
    rst = 1; in_valid = 1; a_s = 16'h0005; b_s = 16'h0005;
    tick();
    rst = 0; in_valid = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    ov = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) ov++;
      tick();
    end
    check("midrst_no_out", ov, 0);
    check("midrst_in_ready_after", in_ready, 1);
    send(16'h00FF, 16'h0100, 0, t);
    get(t, lat, pv);
    check("post_rst_p", pv, 32'h0000FF00);
    tick();

    rise_q.delete();
    for (int k = 0; k < 3; k++) begin
      send(W'($urandom), W'($urandom) | 16'h0001, 1, t);
      acc_t.push_back(t);
    end
    in_valid = 0;
    for (int k = 0; k < 100 && rise_q.size() < 3; k++) tick();
    if (rise_q.size() < 3) timeout("b2b_results");
    else begin
      check("b2b_out_gap0", rise_q[1] - rise_q[0], 18);
      check("b2b_out_gap1", rise_q[2] - rise_q[1], 18);
    end
    check("b2b_acc_gap", acc_t[2] - acc_t[1], 18);
    repeat (3) tick();

    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra, rb;
      bit done;
      ra = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      send(ra, rb, 0, t);
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) done = 1;
        tick();
      end
      if (!done) timeout("rand_handshake");
      repeat ($urandom_range(0, 2)) tick();
    end
    out_ready = 1;

    in_valid8 = 1; a8 = 8'hAB; b8 = 8'hCD;
    t0 = -1;
    for (int k = 0; k < 20 && t0 < 0; k++) begin
      if (in_ready8) t0 = cyc;
      tick();
    end
    in_valid8 = 0;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (out_valid8) begin
        lat = cyc - t0;
        check("w8_p", p8, 16'h88EF);
      end else tick();
    end
    if (lat < 0) timeout("w8_result");
    else check("w8_lat", lat, 5);
    tick();
    check("w8_idle", busy8, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vedic_serial_mult.md
# vedic_serial_mult

Digit-serial WIDTH×WIDTH unsigned multiplier controller that time-shares a single `simple_vedic_4bit` 4×4 multiplier across all 4-bit digit pairs of its operands. It accepts one operand pair over a valid/ready handshake and sequences (WIDTH/4)² partial products through the shared multiplier. It accumulates them shifted into a 2·WIDTH-bit result and presents that result over a second valid/ready handshake. It is the area-minimal multiply resource for the non-critical control paths of the IDDMM datapath.

## Interface
- `WIDTH`, 16, operand width in bits; must be a multiple of 4 and ≥ 8 (elaboration error otherwise)
- `clk`  in  1  the single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept an operand pair
- `a`  in  WIDTH  multiplicand, unsigned
- `b`  in  WIDTH  multiplier, unsigned
- `out_valid`  out  1  product valid
- `out_ready`  in  1  consumer accepts product
- `p`  out  2·WIDTH  product a·b
- `busy`  out  1  high in any state other than IDLE

## Operation
- D = WIDTH/4 digits. FSM states: IDLE, MUL, DONE; reset state IDLE.
- IDLE: `in_ready` = 1.
  - On `in_valid & in_ready`: latch a and b, clear the accumulator, clear digit counters i and j, go to MUL.
- MUL: one partial product per cycle.
  - Compute prod = a[4i+3:4i] × b[4j+3:4j] on the shared 4×4 multiplier.
  - acc ← acc + (prod << 4·(i+j)).
  - i is the inner counter, j the outer counter; both run 0..D−1.
  - After the (i=D−1, j=D−1) update, go to DONE.
- DONE: `out_valid` = 1 and `p` = acc.
  - On `out_ready`, go to IDLE.
- Arithmetic: acc is 2·WIDTH bits; the final sum never exceeds (2^WIDTH−1)², so no overflow occurs and no saturation logic is needed.
- `in_ready` is a decode of state == IDLE. Inputs arriving in MUL or DONE are ignored; the upstream holds them.
- Reset values: `in_ready` 1, `out_valid` 0, `busy` 0, `p` 0, acc 0, counters 0.
- Reset mid-operation (MUL or DONE): the result is discarded, the FSM returns to IDLE, and no `out_valid` pulse is produced.
- `in_valid` asserted during reset is ignored.

## Timing
- Accept handshake in cycle T. MUL occupies cycles T+1 .. T+D². `out_valid` rises in cycle T+D²+1.
  - WIDTH=16: 16 MUL cycles; `out_valid` in T+17.
- `p` and `out_valid` are registered and held stable while `out_valid & ~out_ready`.
- Output handshake in cycle U: `out_valid` = 0 and `in_ready` = 1 in U+1. The earliest next accept is U+1.
- Peak throughput: one product per D²+2 cycles.

## Configuration
- `VEDIC_SERIAL_SKIP_ZERO_EN` defined:
  - If a == 0 or b == 0 at the accept handshake, skip MUL and go directly to DONE with acc = 0.
  - `out_valid` rises in T+1.
- Not defined: every operation takes the full D² MUL cycles, including zero operands; no zero-detect logic is built.

## Structure
- Shared package `vedic_pkg`:
  - FSM state typedef (IDLE, MUL, DONE).
  - `VEDIC_DIGIT_W` = 4.
  - Function for the digit count, WIDTH/`VEDIC_DIGIT_W`.
- Sub-module: exactly one instance of `simple_vedic_4bit`, fed by digit muxes on a and b.
- The shift-add and the counters stay in this module.

## Test plan
- WIDTH=16, a=0x1234, b=0x5678, out_ready=1 -> `p`=0x06260060 with `out_valid` in T+17; `busy` high T+1..T+17.
- a=0xFFFF, b=0xFFFF -> `p`=0xFFFE0001; max carry chain, no overflow.
- Backpressure: out_ready=0 for 5 cycles after `out_valid` -> `p` and `out_valid` stable, `in_ready`=0, and a new `in_valid` is not accepted. Raise out_ready -> `in_ready`=1 in the next cycle.
- a=0, b=0x1234 -> `p`=0.
  - With macro: `out_valid` in T+1.
  - Without macro: `out_valid` in T+17.
- Assert `rst` for 1 cycle at T+8 -> no `out_valid`. `in_ready`=1 during and after reset. A following 0x00FF×0x0100 returns 0x0000FF00.
- Back-to-back: 3 random pairs with `in_valid` held high and out_ready=1 -> 3 correct products spaced 18 cycles apart; WIDTH=8 run checks 0xAB×0xCD=0x88EF after 4 MUL cycles.
